ctrl_bubble_stage: RTL

CTRL_BUBBLE_STAGE -- requirements
Module: ctrl_bubble_stage

---
 rtl/ctrl_bubble_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage: one-deep control-bundle register between decode and
// execute that inserts single-cycle bubbles (stall_i) or multi-cycle bubble
// bursts (bubble_req_i/bubble_len_i), with hold and flush.
// Optional: define BUBBLE_STATS_EN to add the bubble_cnt_o statistics counter.
module ctrl_bubble_stage #(
  parameter int unsigned          CTRL_W     = 8,
  parameter int unsigned          CNT_W      = 3,
  parameter logic [CTRL_W-1:0]    BUBBLE_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              bubble_req_i,
  input  logic [CNT_W-1:0]  bubble_len_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
`ifdef BUBBLE_STATS_EN
  output logic [15:0]       bubble_cnt_o,
`endif
  output logic              stall_o
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  w_remaining_nxt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              w_req_accept;
  logic              w_bubble;
  logic              w_bubble_counted;

  // A request is only taken in IDLE with a non-zero length; bursts ignore it.
  always_comb begin
    w_req_accept     = (r_state == IDLE) && bubble_req_i && (bubble_len_i != '0);
    w_bubble         = stall_i || (r_state == BURST) || w_req_accept;
    w_bubble_counted = !flush_i && !hold_i && w_bubble;
  end

  // Next-state and next-output selection: flush > hold > bubble > load.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_ctrl_nxt      = r_ctrl;
    w_valid_nxt     = r_valid;
    if (flush_i) begin
      w_state_nxt     = IDLE;
      w_remaining_nxt = '0;
      w_ctrl_nxt      = BUBBLE_VAL;
      w_valid_nxt     = 1'b0;
    end else if (!hold_i) begin
      if (w_bubble) begin
        w_ctrl_nxt  = BUBBLE_VAL;
        w_valid_nxt = 1'b0;
      end else begin
        w_ctrl_nxt  = ctrl_i;
        w_valid_nxt = valid_i;
      end
      unique case (r_state)
        IDLE: begin
          // Length 1 is a lone bubble: no BURST state needed.
          if (w_req_accept && (bubble_len_i > CNT_W'(1))) begin
            w_state_nxt     = BURST;
            w_remaining_nxt = bubble_len_i - CNT_W'(1);
          end
        end
        BURST: begin
          if (r_remaining <= CNT_W'(1)) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = '0;
          end else begin
            w_remaining_nxt = r_remaining - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_remaining_nxt = '0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_ctrl      <= BUBBLE_VAL;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

`ifdef BUBBLE_STATS_EN
  logic [15:0] r_bubble_cnt;

  // Saturating count of inserted bubbles (flushes and held cycles excluded).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble_counted && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_bubble_counted;
`endif

  assign ctrl_o  = r_ctrl;
  assign valid_o = r_valid;
  assign stall_o = (r_state == BURST);

endmodule
